fir_mac_sequencer: RTL and testbench
====================================

// Module: fir_mac_sequencer
// PURPOSE
//  Control sequencer for the 4-bank FIR datapath (4 MAC units of 10 taps each, summed by MACSum).
//  Derives the 600 kHz sample strobe from iClk12M and schedules the coefficient-RAM reads,
//  MAC enables, accumulator clears and the sum-delay strobe within each 20-clock sample frame.
//  Also owns the coefficient update mode: it routes host writes (flat tap address 0..39)
//  to the correct bank RAM.
// PARAMETERS
//  SAMPLE_DIV    20  clocks per sample frame (12 MHz / 600 kHz)
//  TAPS_PER_MAC  10  taps per MAC bank; number of banks fixed at 4
//  DATA_W        16  coefficient width
// PORTS
//  iClk12M          in   1   12 MHz system clock
//  iRsn             in   1   asynchronous active-low reset
//  iCoeffUpdateFlag in   1   level; 1 = host requests coefficient update mode
//  iCsnRam          in   1   host RAM chip select, active-low (honoured in UPDATE only)
//  iWrnRam          in   1   host write strobe, active-low (honoured in UPDATE only)
//  iAddrRam         in   6   host flat tap address 0..39
//  iWrDtRam         in   16  host write data
//  oCsnRam          out  4   per-bank RAM chip select, active-low; bit k = bank k
//  oWrnRam          out  1   RAM write enable, active-low
//  oAddrRam         out  4   bank-local RAM address 0..9
//  oWrDtRam         out  16  RAM write data
//  oEnSample600k    out  1   one-clock sample strobe, frame start
//  oClrAcc          out  1   one-clock MAC accumulator clear
//  oEnMul           out  1   MAC multiply-accumulate enable
//  oEnDelay         out  1   one-clock strobe latching the MAC sum into the MACSum delay register
//  oAddrErr         out  1   one-clock pulse: host write to address >= 40 (write dropped)
//  oBusy            out  1   1 in RUN, 0 in IDLE/UPDATE
// BEHAVIOUR
//  Reset (iRsn=0, async): state=IDLE, rCnt=0.
//   Outputs: oCsnRam=4'hF, oWrnRam=1, oAddrRam=0, oWrDtRam=0; all strobes/enables=0; oBusy=0.
//  FSM states IDLE/UPDATE/RUN; outputs registered.
//   IDLE -> UPDATE when flag=1; IDLE -> RUN when flag=0 (first clock after reset release).
//   UPDATE -> RUN on the first clock with flag=0; rCnt restarts at 0.
//   RUN -> UPDATE only at frame end (rCnt==19 and flag=1); no partial frames are ever issued.
//  RUN frame, rCnt = 0..SAMPLE_DIV-1, wraps 19 -> 0:
//   rCnt==0       oEnSample600k=1 and oClrAcc=1 (registered, visible on the next clock).
//   rCnt 1..10    oCsnRam=4'h0, oWrnRam=1, oAddrRam=rCnt-1 (all 4 banks read in parallel).
//   rCnt 2..11    oEnMul=1 (RAM read latency 1 clock): exactly 10 MAC cycles per frame.
//   rCnt==13      oEnDelay=1 (MAC outputs settled; MACSum delay register captures the sum).
//   All other cycles: strobes 0; oCsnRam=4'hF.
//   Strobe period is exactly 20 clocks in steady state.
//  UPDATE: host access decoded combinationally from inputs, then registered (1 clk latency).
//   bank = iAddrRam/10, local = iAddrRam%10; decode via compare chain, no divider.
//   When iCsnRam=0 and iAddrRam<40: oCsnRam[bank]=0 (others 1), oAddrRam=local,
//    oWrnRam=iWrnRam, oWrDtRam=iWrDtRam.
//   When iAddrRam>=40 with iCsnRam=0 and iWrnRam=0: oCsnRam=4'hF and oAddrErr pulses 1 clk.
//   In UPDATE, oEnSample600k/oClrAcc/oEnMul/oEnDelay are held 0.
//  Host strobes outside UPDATE are ignored (no RAM effect, no oAddrErr).
//  Flag toggling mid-frame has no effect until rCnt==19; a flag pulse that returns to 0
//   before rCnt==19 is not seen.
//  Reset mid-frame: immediate return to reset values. After release, the first
//   oEnSample600k appears 2 clocks later (IDLE -> RUN, rCnt=0 registered).
// STRUCTURE
//  Shared package: FIR_SAMPLE_DIV, FIR_TAPS_PER_MAC, FIR_NUM_BANK=4, state encodings
//   ST_IDLE/ST_UPDATE/ST_RUN, frame slot constants SLOT_RD_FIRST=1, SLOT_RD_LAST=10,
//   SLOT_DELAY=13.
//  One sub-module: fir_coeff_addr_decode (6-bit flat address -> 4-bit one-hot-low CSN,
//   4-bit local address, range error); purely combinational, reused by the bench model.
//  Remaining logic stays flat: FSM + frame counter + output registers.
// TESTING
//  1 Reset, flag=0, run 100 clocks -> oEnSample600k period 20; oEnMul high exactly 10 clks
//    per frame, starting 2 clks after the sample strobe; oEnDelay 13 clks after it.
//  2 Flag=1 from reset; write addr 0,9,10,25,39 with data 16'h0101.. ->
//    oCsnRam = E,E,D,B,7 and oAddrRam = 0,9,0,5,9, each one clock after the host strobe.
//  3 In UPDATE, write addr 40 and 63 -> oCsnRam stays F; oAddrErr pulses once per write.
//  4 Raise flag at rCnt==5 in RUN -> frame completes (oEnDelay still fires).
//    UPDATE entered after rCnt==19; drop flag -> sample strobe 2 clks later.
//  5 Assert iRsn=0 at rCnt==7 for 3 clks -> all outputs reset asynchronously.
//    After release, a clean frame is produced with a full 10 oEnMul cycles.
//  6 Host strobes while in RUN (addr 3, iWrnRam=0) -> oWrnRam stays 1, no oAddrErr,
//    and the read schedule is unchanged.

Source files
------------

// File: rtl/fir_mac_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fir_mac_sequencer_pkg
//  Brief    : Shared constants and state encoding for the FIR MAC sequencer.
//  Revision : 1.0
// ============================================================================
package fir_mac_sequencer_pkg;

   localparam int FIR_SAMPLE_DIV   = 20;
   localparam int FIR_TAPS_PER_MAC = 10;
   localparam int FIR_NUM_BANK     = 4;
   localparam int FIR_DATA_W       = 16;

   // Frame slots, counted in rCnt values within a RUN frame
   localparam int SLOT_RD_FIRST = 1;
   localparam int SLOT_RD_LAST  = 10;
   localparam int SLOT_DELAY    = 13;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_UPDATE = 2'd1,
      ST_RUN    = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/fir_coeff_addr_decode.sv
`default_nettype none
// ============================================================================
//  Module   : fir_coeff_addr_decode
//  Brief    : Flat tap address 0..39 -> bank chip select (active-low),
//             bank-local address and out-of-range flag. Purely combinational.
//  Revision : 1.0
// ============================================================================
module fir_coeff_addr_decode
   import fir_mac_sequencer_pkg::*;
(
   input  logic [5:0]              iAddr,
   output logic [FIR_NUM_BANK-1:0] oCsn,
   output logic [3:0]              oLocal,
   output logic                    oErr
);

   // Bank offsets 10/20/30 are 10/4/14 modulo 16, so the local address
   // falls out of a 4-bit subtract on the low nibble.
   always_comb begin
      oCsn   = '1;
      oLocal = 4'd0;
      oErr   = 1'b0;
      if (iAddr < 6'd10) begin
         oCsn   = 4'b1110;
         oLocal = iAddr[3:0];
      end else if (iAddr < 6'd20) begin
         oCsn   = 4'b1101;
         oLocal = iAddr[3:0] - 4'd10;
      end else if (iAddr < 6'd30) begin
         oCsn   = 4'b1011;
         oLocal = iAddr[3:0] - 4'd4;
      end else if (iAddr < 6'd40) begin
         oCsn   = 4'b0111;
         oLocal = iAddr[3:0] - 4'd14;
      end else begin
         oErr   = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fir_mac_sequencer
//  Brief    : 600 kHz frame sequencer for the 4-bank FIR MAC datapath and
//             host coefficient-update router. All outputs registered.
//  Revision : 1.0
// ============================================================================
module fir_mac_sequencer
   import fir_mac_sequencer_pkg::*;
#(
   parameter int SAMPLE_DIV   = FIR_SAMPLE_DIV,
   parameter int TAPS_PER_MAC = FIR_TAPS_PER_MAC,
   parameter int DATA_W       = FIR_DATA_W
) (
   input  logic                    iClk12M,
   input  logic                    iRsn,
   input  logic                    iCoeffUpdateFlag,
   input  logic                    iCsnRam,
   input  logic                    iWrnRam,
   input  logic [5:0]              iAddrRam,
   input  logic [DATA_W-1:0]       iWrDtRam,
   output logic [FIR_NUM_BANK-1:0] oCsnRam,
   output logic                    oWrnRam,
   output logic [3:0]              oAddrRam,
   output logic [DATA_W-1:0]       oWrDtRam,
   output logic                    oEnSample600k,
   output logic                    oClrAcc,
   output logic                    oEnMul,
   output logic                    oEnDelay,
   output logic                    oAddrErr,
   output logic                    oBusy
);

   localparam int CNT_W   = $clog2(SAMPLE_DIV);
   localparam int RD_LAST = SLOT_RD_FIRST + TAPS_PER_MAC - 1;

   state_t                  rState, wNextState;
   logic [CNT_W-1:0]        rCnt, wNextCnt;

   logic [FIR_NUM_BANK-1:0] rCsn, wCsn;
   logic                    rWrn, wWrn;
   logic [3:0]              rAddr, wAddr;
   logic [DATA_W-1:0]       rWrDt, wWrDt;
   logic                    rEnSample, wEnSample;
   logic                    rClrAcc, wClrAcc;
   logic                    rEnMul, wEnMul;
   logic                    rEnDelay, wEnDelay;
   logic                    rAddrErr, wAddrErr;

   logic [FIR_NUM_BANK-1:0] wDecCsn;
   logic [3:0]              wDecLocal;
   logic                    wDecErr;

   logic                    wLastSlot, wRdSlot, wMulSlot, wDelaySlot;

   fir_coeff_addr_decode u_addrDecode (
      .iAddr  (iAddrRam),
      .oCsn   (wDecCsn),
      .oLocal (wDecLocal),
      .oErr   (wDecErr)
   );

   assign wLastSlot  = (rCnt == CNT_W'(SAMPLE_DIV - 1));
   assign wRdSlot    = (int'(rCnt) >= SLOT_RD_FIRST) && (int'(rCnt) <= RD_LAST);
   // MAC enable trails the read window by the one-clock RAM latency
   assign wMulSlot   = (int'(rCnt) >= SLOT_RD_FIRST + 1) && (int'(rCnt) <= RD_LAST + 1);
   assign wDelaySlot = (int'(rCnt) == SLOT_DELAY);

   always_comb begin
      wNextState = rState;
      wNextCnt   = rCnt;
      wCsn       = '1;
      wWrn       = 1'b1;
      wAddr      = 4'd0;
      wWrDt      = '0;
      wEnSample  = 1'b0;
      wClrAcc    = 1'b0;
      wEnMul     = 1'b0;
      wEnDelay   = 1'b0;
      wAddrErr   = 1'b0;
      case (rState)
         ST_IDLE: begin
            wNextCnt   = '0;
            wNextState = iCoeffUpdateFlag ? ST_UPDATE : ST_RUN;
         end
         ST_UPDATE: begin
            wNextCnt = '0;
            if (!iCoeffUpdateFlag) wNextState = ST_RUN;
            if (!iCsnRam) begin
               if (!wDecErr) begin
                  wCsn  = wDecCsn;
                  wAddr = wDecLocal;
                  wWrn  = iWrnRam;
                  wWrDt = iWrDtRam;
               end else if (!iWrnRam) begin
                  wAddrErr = 1'b1;
               end
            end
         end
         ST_RUN: begin
            // Mode change only at frame end so a frame is never truncated
            if (wLastSlot) begin
               wNextCnt = '0;
               if (iCoeffUpdateFlag) wNextState = ST_UPDATE;
            end else begin
               wNextCnt = rCnt + 1'b1;
            end
            wEnSample = (rCnt == '0);
            wClrAcc   = (rCnt == '0);
            if (wRdSlot) begin
               wCsn  = '0;
               wAddr = 4'(rCnt - 1'b1);
            end
            wEnMul   = wMulSlot;
            wEnDelay = wDelaySlot;
         end
         default: begin
            wNextState = ST_IDLE;
            wNextCnt   = '0;
         end
      endcase
   end

   always_ff @(posedge iClk12M or negedge iRsn) begin
      if (!iRsn) begin
         rState    <= ST_IDLE;
         rCnt      <= '0;
         rCsn      <= '1;
         rWrn      <= 1'b1;
         rAddr     <= 4'd0;
         rWrDt     <= '0;
         rEnSample <= 1'b0;
         rClrAcc   <= 1'b0;
         rEnMul    <= 1'b0;
         rEnDelay  <= 1'b0;
         rAddrErr  <= 1'b0;
      end else begin
         rState    <= wNextState;
         rCnt      <= wNextCnt;
         rCsn      <= wCsn;
         rWrn      <= wWrn;
         rAddr     <= wAddr;
         rWrDt     <= wWrDt;
         rEnSample <= wEnSample;
         rClrAcc   <= wClrAcc;
         rEnMul    <= wEnMul;
         rEnDelay  <= wEnDelay;
         rAddrErr  <= wAddrErr;
      end
   end

   assign oCsnRam       = rCsn;
   assign oWrnRam       = rWrn;
   assign oAddrRam      = rAddr;
   assign oWrDtRam      = rWrDt;
   assign oEnSample600k = rEnSample;
   assign oClrAcc       = rClrAcc;
   assign oEnMul        = rEnMul;
   assign oEnDelay      = rEnDelay;
   assign oAddrErr      = rAddrErr;
   assign oBusy         = (rState == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_mac_sequencer
//  Brief    : Directed self-checking bench for fir_mac_sequencer.
//  Revision : 1.0
// ============================================================================
module tb_fir_mac_sequencer;

   logic        iClk12M;
   logic        iRsn;
   logic        iCoeffUpdateFlag;
   logic        iCsnRam;
   logic        iWrnRam;
   logic [5:0]  iAddrRam;
   logic [15:0] iWrDtRam;
   logic [3:0]  oCsnRam;
   logic        oWrnRam;
   logic [3:0]  oAddrRam;
   logic [15:0] oWrDtRam;
   logic        oEnSample600k;
   logic        oClrAcc;
   logic        oEnMul;
   logic        oEnDelay;
   logic        oAddrErr;
   logic        oBusy;

   int errors = 0;
   int checks = 0;

   logic [5:0] wrAddr [5] = '{6'd0, 6'd9, 6'd10, 6'd25, 6'd39};
   logic [3:0] expCsn [5] = '{4'hE, 4'hE, 4'hD, 4'hB, 4'h7};
   logic [3:0] expLoc [5] = '{4'd0, 4'd9, 4'd0, 4'd5, 4'd9};
   logic [5:0] badAddr [2] = '{6'd40, 6'd63};

   fir_mac_sequencer dut (
      .iClk12M          (iClk12M),
      .iRsn             (iRsn),
      .iCoeffUpdateFlag (iCoeffUpdateFlag),
      .iCsnRam          (iCsnRam),
      .iWrnRam          (iWrnRam),
      .iAddrRam         (iAddrRam),
      .iWrDtRam         (iWrDtRam),
      .oCsnRam          (oCsnRam),
      .oWrnRam          (oWrnRam),
      .oAddrRam         (oAddrRam),
      .oWrDtRam         (oWrDtRam),
      .oEnSample600k    (oEnSample600k),
      .oClrAcc          (oClrAcc),
      .oEnMul           (oEnMul),
      .oEnDelay         (oEnDelay),
      .oAddrErr         (oAddrErr),
      .oBusy            (oBusy)
   );

   initial iClk12M = 1'b0;
   always #5 iClk12M = ~iClk12M;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Returns clocks until the next sample strobe, -1 if none within budget
   task automatic waitStrobe(output int n);
      n = -1;
      for (int i = 1; i <= 50; i++) begin
         @(negedge iClk12M);
         if (oEnSample600k) begin
            n = i;
            break;
         end
      end
   endtask

   // Call with the sample strobe visible (index 0); observes indices 1..20
   task automatic measureFrame(input int raiseAt, output int mulCnt, output int mulFirst,
                               output int delayIdx, output int strobeIdx, output int rdBad,
                               output int wrnLow, output int errSeen, output int busy19,
                               output int clrCnt);
      mulCnt = 0; mulFirst = -1; delayIdx = -1; strobeIdx = -1; rdBad = 0;
      wrnLow = 0; errSeen = 0; busy19 = -1; clrCnt = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge iClk12M);
         if (i == raiseAt) iCoeffUpdateFlag = 1'b1;
         if (oEnMul) begin
            mulCnt++;
            if (mulFirst < 0) mulFirst = i;
         end
         if (oEnDelay && delayIdx < 0) delayIdx = i;
         if (oEnSample600k && strobeIdx < 0) strobeIdx = i;
         if (oClrAcc) clrCnt++;
         if (!oWrnRam) wrnLow++;
         if (oAddrErr) errSeen++;
         if (i >= 1 && i <= 10) begin
            if (oCsnRam !== 4'h0 || oAddrRam !== 4'(i - 1) || oWrnRam !== 1'b1) rdBad++;
         end else if (oCsnRam !== 4'hF) begin
            rdBad++;
         end
         if (i == 19) busy19 = int'(oBusy);
      end
   endtask

   initial begin
      int n, mulCnt, mulFirst, delayIdx, strobeIdx, rdBad, wrnLow, errSeen, busy19, clrCnt;
      int updStrobes;
      iRsn = 1'b0; iCoeffUpdateFlag = 1'b0; iCsnRam = 1'b1; iWrnRam = 1'b1;
      iAddrRam = 6'd0; iWrDtRam = 16'h0000;
      updStrobes = 0;
      repeat (3) @(negedge iClk12M);

      chk("rst_csn", 32'(oCsnRam), 32'hF);
      chk("rst_wrn", 32'(oWrnRam), 32'h1);
      chk("rst_addr", 32'(oAddrRam), 32'h0);
      chk("rst_wrdt", 32'(oWrDtRam), 32'h0);
      chk("rst_strobes", 32'({oEnSample600k, oClrAcc, oEnMul, oEnDelay, oAddrErr}), 32'h0);
      chk("rst_busy", 32'(oBusy), 32'h0);

      // Coefficient writes straight out of reset
      iCoeffUpdateFlag = 1'b1;
      iRsn = 1'b1;
      @(negedge iClk12M);
      chk("upd_busy", 32'(oBusy), 32'h0);
      for (int k = 0; k < 5; k++) begin
         iCsnRam = 1'b0; iWrnRam = 1'b0; iAddrRam = wrAddr[k];
         iWrDtRam = {8'(k + 1), 8'(k + 1)};
         @(negedge iClk12M);
         chk($sformatf("wr%0d_csn", k), 32'(oCsnRam), 32'(expCsn[k]));
         chk($sformatf("wr%0d_addr", k), 32'(oAddrRam), 32'(expLoc[k]));
         chk($sformatf("wr%0d_wrn", k), 32'(oWrnRam), 32'h0);
         chk($sformatf("wr%0d_data", k), 32'(oWrDtRam), 32'(16'h0101 * (k + 1)));
         updStrobes += int'(oEnSample600k) + int'(oClrAcc) + int'(oEnMul) + int'(oEnDelay);
      end
      iCsnRam = 1'b1; iWrnRam = 1'b1;
      @(negedge iClk12M);
      chk("wr_idle_csn", 32'(oCsnRam), 32'hF);
      chk("wr_idle_wrn", 32'(oWrnRam), 32'h1);

      // Out-of-range writes
      for (int k = 0; k < 2; k++) begin
         iCsnRam = 1'b0; iWrnRam = 1'b0; iAddrRam = badAddr[k];
         @(negedge iClk12M);
         chk($sformatf("bad%0d_err", k), 32'(oAddrErr), 32'h1);
         chk($sformatf("bad%0d_csn", k), 32'(oCsnRam), 32'hF);
         updStrobes += int'(oEnSample600k) + int'(oClrAcc) + int'(oEnMul) + int'(oEnDelay);
         iCsnRam = 1'b1; iWrnRam = 1'b1;
         @(negedge iClk12M);
         chk($sformatf("bad%0d_err_clr", k), 32'(oAddrErr), 32'h0);
      end
      chk("upd_strobes_held", 32'(updStrobes), 32'h0);

      // Leave UPDATE: strobe two clocks after the flag drops
      iCoeffUpdateFlag = 1'b0;
      waitStrobe(n);
      chk("upd_to_run_lat", 32'(n), 32'd2);
      chk("first_clr", 32'(oClrAcc), 32'h1);

      // Steady-state frames
      for (int f = 0; f < 4; f++) begin
         measureFrame(-1, mulCnt, mulFirst, delayIdx, strobeIdx, rdBad, wrnLow, errSeen, busy19, clrCnt);
         chk($sformatf("f%0d_mul_cnt", f), 32'(mulCnt), 32'd10);
         chk($sformatf("f%0d_mul_first", f), 32'(mulFirst), 32'd2);
         chk($sformatf("f%0d_delay", f), 32'(delayIdx), 32'd13);
         chk($sformatf("f%0d_period", f), 32'(strobeIdx), 32'd20);
         chk($sformatf("f%0d_rd_sched", f), 32'(rdBad), 32'd0);
         chk($sformatf("f%0d_busy", f), 32'(busy19), 32'd1);
         chk($sformatf("f%0d_clr", f), 32'(clrCnt), 32'd1);
      end

      // Host strobes during RUN are ignored
      iCsnRam = 1'b0; iWrnRam = 1'b0; iAddrRam = 6'd3; iWrDtRam = 16'hBEEF;
      measureFrame(-1, mulCnt, mulFirst, delayIdx, strobeIdx, rdBad, wrnLow, errSeen, busy19, clrCnt);
      iCsnRam = 1'b1; iWrnRam = 1'b1;
      chk("run_host_wrn", 32'(wrnLow), 32'd0);
      chk("run_host_err", 32'(errSeen), 32'd0);
      chk("run_host_rd", 32'(rdBad), 32'd0);
      chk("run_host_mul", 32'(mulCnt), 32'd10);
      chk("run_host_period", 32'(strobeIdx), 32'd20);

      // Flag raised at rCnt==5: frame completes, then UPDATE
      measureFrame(4, mulCnt, mulFirst, delayIdx, strobeIdx, rdBad, wrnLow, errSeen, busy19, clrCnt);
      chk("mid_mul_cnt", 32'(mulCnt), 32'd10);
      chk("mid_delay", 32'(delayIdx), 32'd13);
      chk("mid_no_strobe", 32'(strobeIdx), 32'hFFFF_FFFF);
      chk("mid_busy_upd", 32'(busy19), 32'd0);
      chk("mid_rd_sched", 32'(rdBad), 32'd0);
      iCsnRam = 1'b0; iWrnRam = 1'b0; iAddrRam = 6'd25; iWrDtRam = 16'h1234;
      @(negedge iClk12M);
      chk("mid_wr_csn", 32'(oCsnRam), 32'hB);
      chk("mid_wr_addr", 32'(oAddrRam), 32'd5);
      iCsnRam = 1'b1; iWrnRam = 1'b1;
      iCoeffUpdateFlag = 1'b0;
      waitStrobe(n);
      chk("mid_resume_lat", 32'(n), 32'd2);

      // Asynchronous reset at rCnt==7
      repeat (6) @(negedge iClk12M);
      chk("pre_rst_mul", 32'(oEnMul), 32'h1);
      chk("pre_rst_csn", 32'(oCsnRam), 32'h0);
      iRsn = 1'b0;
      #1;
      chk("async_csn", 32'(oCsnRam), 32'hF);
      chk("async_mul", 32'(oEnMul), 32'h0);
      chk("async_addr", 32'(oAddrRam), 32'h0);
      chk("async_busy", 32'(oBusy), 32'h0);
      repeat (3) @(negedge iClk12M);
      chk("rst_hold_strobe", 32'(oEnSample600k), 32'h0);
      iRsn = 1'b1;
      waitStrobe(n);
      chk("rst_release_lat", 32'(n), 32'd2);
      measureFrame(-1, mulCnt, mulFirst, delayIdx, strobeIdx, rdBad, wrnLow, errSeen, busy19, clrCnt);
      chk("post_rst_mul_cnt", 32'(mulCnt), 32'd10);
      chk("post_rst_mul_first", 32'(mulFirst), 32'd2);
      chk("post_rst_delay", 32'(delayIdx), 32'd13);
      chk("post_rst_period", 32'(strobeIdx), 32'd20);
      chk("post_rst_rd", 32'(rdBad), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
